// File: rtl/vector_checker.sv
// vector_checker: applies stored test vectors to an external DUT, waits a fixed
// settle time, compares the masked response and keeps pass/fail statistics.
module vector_checker #(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  vec_inputs,
    input  logic [OUT_W-1:0] vec_expected,
    input  logic [OUT_W-1:0] vec_mask,
    input  logic             vec_last,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             mismatch,
    output logic [31:0]      vec_count,
    output logic [31:0]      err_count,
    output logic [31:0]      fail_index,
    output logic             done,
    output logic             pass
);

    // A settle time below one cycle is meaningless; clamp so the counter logic stays sound.
    localparam int              SET_MIN     = (SETTLE < 1) ? 1 : SETTLE;
    localparam int              CNT_W       = $clog2(SET_MIN + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SET_MIN);
    localparam logic [31:0]     NO_FAIL     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;

    // Vector captured at the handshake; held until the next accepted vector.
    logic [OUT_W-1:0]   exp_p1;
    logic [OUT_W-1:0]   mask_p1;
    logic               last_p1;

    logic [CNT_W-1:0]   settle_cnt;
    logic               handshake;
    logic               settle_done;
    logic               fail_now;

    // Saturating increment: statistics stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end
        return value + 32'd1;
    endfunction

    // A vector fails when any enabled bit of the response differs from expectation.
    function automatic logic vec_fails(
        input logic [OUT_W-1:0] response,
        input logic [OUT_W-1:0] expected,
        input logic [OUT_W-1:0] mask
    );
        return |((response ^ expected) & mask);
    endfunction

    assign handshake   = (state == S_FETCH) && vec_valid;
    assign settle_done = (settle_cnt == CNT_W'(1));
    assign fail_now    = vec_fails(dut_out, exp_p1, mask_p1);

    // State register; reset overrides every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the state-derived handshake/status outputs.
    always_comb begin
        next_state = state;
        vec_ready  = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                vec_ready = 1'b1;
                if (vec_valid) begin
                    next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_done) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                next_state = last_p1 ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                pass = (err_count == 32'd0);
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Capture the expected value, mask and last flag of the accepted vector.
    always_ff @(posedge clock) begin
        if (handshake) begin
            exp_p1  <= vec_expected;
            mask_p1 <= vec_mask;
            last_p1 <= vec_last;
        end
    end

    // Stimulus register: changes only on an accepted vector, otherwise holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            dut_in <= '0;
        end else if (handshake) begin
            dut_in <= vec_inputs;
        end
    end

    // Settle countdown: loaded on acceptance, steps down while waiting for the DUT.
    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (handshake) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == S_SETTLE && !settle_done) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    // Statistics update as CHECK is left; reset in the same cycle discards it.
    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch   <= 1'b0;
            vec_count  <= 32'd0;
            err_count  <= 32'd0;
            fail_index <= NO_FAIL;
        end else begin
            mismatch <= 1'b0;
            if (state == S_CHECK) begin
                vec_count <= sat_inc(vec_count);
                if (fail_now) begin
                    mismatch  <= 1'b1;
                    err_count <= sat_inc(err_count);
                    // Only the first failure of the run records its index.
                    if (err_count == 32'd0) begin
                        fail_index <= vec_count;
                    end
                end
            end
        end
    end

endmodule
